// File: rtl/idma_axis_frame_tagger_pkg.sv
// Shared types for the AXI-Stream frame tagger: stream beat layout, the
// tagging FSM states and a keep-byte popcount.
package idma_axis_frame_tagger_pkg;

    localparam int unsigned DataWidth    = 64;
    localparam int unsigned StrbWidth    = DataWidth / 8;
    localparam int unsigned IdWidth      = 4;
    localparam int unsigned DestWidth    = 4;
    localparam int unsigned UserWidth    = 8;
    localparam int unsigned KeepCntWidth = $clog2(StrbWidth + 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic [StrbWidth-1:0] keep;
        logic                 last;
        logic [IdWidth-1:0]   id;
        logic [DestWidth-1:0] dest;
        logic [UserWidth-1:0] user;
    } axis_t_chan_t;

    typedef struct packed {
        axis_t_chan_t t;
        logic         tvalid;
    } axis_req_t;

    typedef struct packed {
        logic tready;
    } axis_rsp_t;

    typedef enum logic {
        TAG_IDLE,
        TAG_ACTIVE
    } tag_state_e;

    function automatic logic [KeepCntWidth-1:0] keep_popcount(input logic [StrbWidth-1:0] keep);
        logic [KeepCntWidth-1:0] n;
        n = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            n = n + KeepCntWidth'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/idma_axis_frame_tagger_skid.sv
// Two-entry skid buffer: registered output, registered ready, one beat per
// cycle when the consumer keeps up.
module idma_axis_frame_tagger_skid
    import idma_axis_frame_tagger_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  axis_t_chan_t in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output axis_t_chan_t out_data_o,
    output logic         busy_o
);

    axis_t_chan_t main_reg;
    axis_t_chan_t spare_reg;
    logic         main_valid_reg;
    logic         spare_valid_reg;
    logic         ready_reg;
    logic         in_fire;

    assign in_fire = in_valid_i & ready_reg;

    // The spare slot only fills while the main slot is stalled; ready drops
    // as soon as it holds a beat so nothing is ever overwritten.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_reg        <= '0;
            spare_reg       <= '0;
            main_valid_reg  <= 1'b0;
            spare_valid_reg <= 1'b0;
            ready_reg       <= 1'b0;
        end else if (!main_valid_reg || out_ready_i) begin
            if (spare_valid_reg) begin
                main_reg        <= spare_reg;
                main_valid_reg  <= 1'b1;
                spare_valid_reg <= 1'b0;
            end else begin
                main_valid_reg <= in_fire;
                if (in_fire) begin
                    main_reg <= in_data_i;
                end
            end
            ready_reg <= 1'b1;
        end else if (in_fire) begin
            spare_reg       <= in_data_i;
            spare_valid_reg <= 1'b1;
            ready_reg       <= 1'b0;
        end else begin
            ready_reg <= ~spare_valid_reg;
        end
    end

    assign in_ready_o  = ready_reg;
    assign out_valid_o = main_valid_reg;
    assign out_data_o  = main_reg;
    assign busy_o      = main_valid_reg | spare_valid_reg;

endmodule

// File: rtl/idma_axis_frame_tagger.sv
// Cuts the DMA output stream into frames of a programmable byte length by
// rewriting t.last, and reports frame completion, short frames and overruns.
module idma_axis_frame_tagger
    import idma_axis_frame_tagger_pkg::*;
#(
    parameter int unsigned TFLenWidth = 24,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [TFLenWidth-1:0] frame_len_i,
    input  axis_req_t             axis_in_req_i,
    output axis_rsp_t             axis_in_rsp_o,
    output axis_req_t             axis_out_req_o,
    input  axis_rsp_t             axis_out_rsp_i,
    output logic                  frame_done_o,
    output logic                  short_frame_o,
    output logic                  overrun_o,
    output logic [CntWidth-1:0]   frames_cnt_o,
    output logic                  busy_o
);

    localparam int unsigned SumWidth = TFLenWidth + 1;

    tag_state_e              state_reg;
    logic [TFLenWidth-1:0]   byte_cnt_reg;
    logic [TFLenWidth-1:0]   latched_len_reg;
    logic                    short_frame_reg;
    logic                    overrun_reg;
    logic                    frame_done_reg;
    logic [CntWidth-1:0]     frames_cnt_reg;

    logic                    in_ready;
    logic                    in_fire;
    logic                    out_valid;
    logic                    out_fire;
    logic                    skid_busy;
    axis_t_chan_t            out_beat;
    axis_t_chan_t            tagged_beat;

    logic [KeepCntWidth-1:0] nbytes;
    logic [TFLenWidth-1:0]   eff_len;
    logic [TFLenWidth-1:0]   base_cnt;
    logic [SumWidth-1:0]     sum;
    logic                    bounded;
    logic                    len_hit;
    logic                    out_last;

    assign in_fire  = axis_in_req_i.tvalid & in_ready;
    assign out_fire = out_valid & axis_out_rsp_i.tready;
    assign nbytes   = keep_popcount(axis_in_req_i.t.keep);

    // A beat arriving in IDLE opens a new frame and is judged against the
    // length being latched right now, counting from zero.
    always_comb begin
        eff_len  = (state_reg == TAG_IDLE) ? frame_len_i : latched_len_reg;
        base_cnt = (state_reg == TAG_IDLE) ? '0 : byte_cnt_reg;
        sum      = {1'b0, base_cnt} + SumWidth'(nbytes);
        bounded  = enable_i & (eff_len != '0);
        len_hit  = bounded & (sum >= {1'b0, eff_len});
        out_last = len_hit | axis_in_req_i.t.last;
        tagged_beat      = axis_in_req_i.t;
        tagged_beat.last = out_last;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= TAG_IDLE;
            byte_cnt_reg    <= '0;
            latched_len_reg <= '0;
            short_frame_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            short_frame_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            if (in_fire) begin
                if (state_reg == TAG_IDLE) begin
                    latched_len_reg <= frame_len_i;
                end
                if (out_last) begin
                    state_reg    <= TAG_IDLE;
                    byte_cnt_reg <= '0;
                end else begin
                    state_reg    <= TAG_ACTIVE;
                    byte_cnt_reg <= sum[TFLenWidth-1:0];
                end
                overrun_reg     <= len_hit & (sum > {1'b0, eff_len});
                short_frame_reg <= ~len_hit & axis_in_req_i.t.last & bounded;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_done_reg <= 1'b0;
            frames_cnt_reg <= '0;
        end else begin
            frame_done_reg <= out_fire & out_beat.last;
            if (out_fire && out_beat.last) begin
                frames_cnt_reg <= frames_cnt_reg + CntWidth'(1);
            end
        end
    end

    idma_axis_frame_tagger_skid i_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (axis_in_req_i.tvalid),
        .in_ready_o  (in_ready),
        .in_data_i   (tagged_beat),
        .out_valid_o (out_valid),
        .out_ready_i (axis_out_rsp_i.tready),
        .out_data_o  (out_beat),
        .busy_o      (skid_busy)
    );

    assign axis_in_rsp_o  = '{tready: in_ready};
    assign axis_out_req_o = '{t: out_beat, tvalid: out_valid};
    assign frame_done_o   = frame_done_reg;
    assign short_frame_o  = short_frame_reg;
    assign overrun_o      = overrun_reg;
    assign frames_cnt_o   = frames_cnt_reg;
    assign busy_o         = (state_reg == TAG_ACTIVE) | skid_busy;

endmodule
